frame_triple_buffer_ctrl: RTL and testbench

FRAME_TRIPLE_BUFFER_CTRL -- requirements
Module: frame_triple_buffer_ctrl

---
 rtl/frame_buf_pkg.sv | 19 +
 rtl/rise_edge_det.sv | 22 ++
 rtl/frame_triple_buffer_ctrl.sv | 178 +++++++++++++++++
 tb/tb_frame_triple_buffer_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buf_pkg.sv
// Shared types and reset constants for the triple-buffer frame controller.
package frame_buf_pkg;

  // Scheduler states: parked, waiting for the first captured frame, steady state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Index of one of the three frame buffers
  typedef logic [1:0] buf_idx_t;

  // Role assignment after reset or while idle: writer 0, reader 1, spare 2
  localparam buf_idx_t IDX_W_RST = 2'd0;
  localparam buf_idx_t IDX_R_RST = 2'd1;
  localparam buf_idx_t IDX_S_RST = 2'd2;

endpackage : frame_buf_pkg

// File: rtl/rise_edge_det.sv
// Single-bit rising-edge detector; the pulse is high in the first cycle the input is sampled high.
module rise_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_c_o
);

  logic d_q;

  // Delayed copy of the input used as the edge reference
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_c_o = d_i & ~d_q;

endmodule : rise_edge_det

// File: rtl/frame_triple_buffer_ctrl.sv
// Triple-buffer scheduler between a frame writer and a frame reader.
// Roles W (writer), R (reader) and S (spare) always form a permutation of {0,1,2}.
module frame_triple_buffer_ctrl
  import frame_buf_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   BUFFER0    = ADDR_WIDTH'(32'h30880000),
  parameter logic [ADDR_WIDTH-1:0]   LENGTH     = ADDR_WIDTH'(32'h0005DC00),
  parameter int unsigned             CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  wr_done,
  input  logic                  rd_done,
  output logic                  wr_go,
  output logic                  rd_go,
  output logic [ADDR_WIDTH-1:0] wr_base,
  output logic [ADDR_WIDTH-1:0] rd_base,
  output logic [1:0]            wr_idx,
  output logic [1:0]            rd_idx,
  output logic                  fresh,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  repeat_cnt
);

  logic wr_rise_c;
  logic rd_rise_c;

  state_e                state_q, state_d;
  buf_idx_t              w_q, w_d;
  buf_idx_t              r_q, r_d;
  buf_idx_t              s_q, s_d;
  logic                  fresh_q, fresh_d;
  logic                  wr_go_q, wr_go_d;
  logic                  rd_go_q, rd_go_d;
  logic [CNT_WIDTH-1:0]  frame_q, frame_d;
  logic [CNT_WIDTH-1:0]  drop_q, drop_d;
  logic [CNT_WIDTH-1:0]  rep_q, rep_d;
  logic [ADDR_WIDTH-1:0] wr_base_q;
  logic [ADDR_WIDTH-1:0] rd_base_q;

  function automatic logic [ADDR_WIDTH-1:0] base_of(input buf_idx_t idx);
    return BUFFER0 + ADDR_WIDTH'(idx) * LENGTH;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  rise_edge_det u_wr_edge (
    .clk      (clk),
    .reset    (reset),
    .d_i      (wr_done),
    .rise_c_o (wr_rise_c)
  );

  rise_edge_det u_rd_edge (
    .clk      (clk),
    .reset    (reset),
    .d_i      (rd_done),
    .rise_c_o (rd_rise_c)
  );

  // Next-state, role rotation and counter updates
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    r_d     = r_q;
    s_d     = s_q;
    fresh_d = fresh_q;
    frame_d = frame_q;
    drop_d  = drop_q;
    rep_d   = rep_q;

    if (!enable) begin
      state_d = ST_IDLE;
      w_d     = IDX_W_RST;
      r_d     = IDX_R_RST;
      s_d     = IDX_S_RST;
      fresh_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_FIRST;
        end
        ST_FIRST: begin
          // First completed frame goes straight to the reader
          if (wr_rise_c) begin
            w_d     = r_q;
            r_d     = w_q;
            fresh_d = 1'b0;
            frame_d = sat_inc(frame_q);
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (wr_rise_c && rd_rise_c) begin
            // Reader takes the frame just finished; an unread spare is discarded
            r_d     = w_q;
            w_d     = s_q;
            s_d     = r_q;
            fresh_d = 1'b0;
            if (fresh_q) drop_d = sat_inc(drop_q);
          end else if (wr_rise_c) begin
            w_d     = s_q;
            s_d     = w_q;
            fresh_d = 1'b1;
            if (fresh_q) drop_d = sat_inc(drop_q);
          end else if (rd_rise_c) begin
            if (fresh_q) begin
              r_d     = s_q;
              s_d     = r_q;
              fresh_d = 1'b0;
            end else begin
              rep_d = sat_inc(rep_q);
            end
          end
          if (wr_rise_c) frame_d = sat_inc(frame_q);
        end
        default: begin
          state_d = ST_IDLE;
          w_d     = IDX_W_RST;
          r_d     = IDX_R_RST;
          s_d     = IDX_S_RST;
          fresh_d = 1'b0;
        end
      endcase
    end

    wr_go_d = (state_d != ST_IDLE);
    rd_go_d = (state_d == ST_RUN);
  end

  // State, roles, counters and bases
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      w_q       <= IDX_W_RST;
      r_q       <= IDX_R_RST;
      s_q       <= IDX_S_RST;
      fresh_q   <= 1'b0;
      wr_go_q   <= 1'b0;
      rd_go_q   <= 1'b0;
      frame_q   <= '0;
      drop_q    <= '0;
      rep_q     <= '0;
      wr_base_q <= base_of(IDX_W_RST);
      rd_base_q <= base_of(IDX_R_RST);
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      r_q       <= r_d;
      s_q       <= s_d;
      fresh_q   <= fresh_d;
      wr_go_q   <= wr_go_d;
      rd_go_q   <= rd_go_d;
      frame_q   <= frame_d;
      drop_q    <= drop_d;
      rep_q     <= rep_d;
      wr_base_q <= base_of(w_d);
      rd_base_q <= base_of(r_d);
    end
  end

  assign wr_go      = wr_go_q;
  assign rd_go      = rd_go_q;
  assign wr_base    = wr_base_q;
  assign rd_base    = rd_base_q;
  assign wr_idx     = w_q;
  assign rd_idx     = r_q;
  assign fresh      = fresh_q;
  assign frame_cnt  = frame_q;
  assign drop_cnt   = drop_q;
  assign repeat_cnt = rep_q;

endmodule : frame_triple_buffer_ctrl

// File: tb/tb_frame_triple_buffer_ctrl.sv
// Self-checking bench: directed vector table, hand sequences and random stimulus vs. a reference model.
module tb_frame_triple_buffer_ctrl;

  localparam logic [31:0] B0   = 32'h30880000;
  localparam logic [31:0] LEN  = 32'h0005DC00;
  localparam int          CMAX = 255;

  logic        clk;
  logic        reset, enable, wr_done, rd_done;
  logic        wr_go, rd_go, fresh;
  logic [31:0] wr_base, rd_base;
  logic [1:0]  wr_idx, rd_idx;
  logic [7:0]  frame_cnt, drop_cnt, repeat_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_mode;   // 0 idle, 1 waiting for first frame, 2 running
  int m_w, m_r, m_s;
  bit m_fresh, m_pw, m_pr;
  int m_frame, m_drop, m_rep;

  typedef struct {
    bit rst, en, wr, rd;
    int w, r, fr, fc, dc, rc, wg, rg;
  } vec_t;

  vec_t tbl[19];

  frame_triple_buffer_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .wr_done    (wr_done),
    .rd_done    (rd_done),
    .wr_go      (wr_go),
    .rd_go      (rd_go),
    .wr_base    (wr_base),
    .rd_base    (rd_base),
    .wr_idx     (wr_idx),
    .rd_idx     (rd_idx),
    .fresh      (fresh),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .repeat_cnt (repeat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit wr, input bit rd);
    bit we, re;
    int t;
    if (rst) begin
      m_mode = 0; m_w = 0; m_r = 1; m_s = 2; m_fresh = 0;
      m_frame = 0; m_drop = 0; m_rep = 0; m_pw = 0; m_pr = 0;
      return;
    end
    we = wr && !m_pw;
    re = rd && !m_pr;
    m_pw = wr;
    m_pr = rd;
    if (!en) begin
      m_mode = 0; m_w = 0; m_r = 1; m_s = 2; m_fresh = 0;
      return;
    end
    case (m_mode)
      0: m_mode = 1;
      1: if (we) begin
           t = m_w; m_w = m_r; m_r = t;
           m_frame = sat(m_frame);
           m_mode = 2;
         end
      default: begin
        if (we && re) begin
          t = m_r; m_r = m_w; m_w = m_s; m_s = t;
          if (m_fresh) m_drop = sat(m_drop);
          m_fresh = 0;
        end else if (we) begin
          t = m_w; m_w = m_s; m_s = t;
          if (m_fresh) m_drop = sat(m_drop);
          m_fresh = 1;
        end else if (re) begin
          if (m_fresh) begin
            t = m_r; m_r = m_s; m_s = t;
            m_fresh = 0;
          end else begin
            m_rep = sat(m_rep);
          end
        end
        if (we) m_frame = sat(m_frame);
      end
    endcase
  endtask

  task automatic check_model();
    logic [31:0] eb;
    chk("wr_idx", 32'(wr_idx), 32'(m_w));
    chk("rd_idx", 32'(rd_idx), 32'(m_r));
    chk("fresh", 32'(fresh), 32'(m_fresh));
    chk("wr_go", 32'(wr_go), 32'(m_mode != 0));
    chk("rd_go", 32'(rd_go), 32'(m_mode == 2));
    eb = B0 + 32'(m_w) * LEN;
    chk("wr_base", wr_base, eb);
    eb = B0 + 32'(m_r) * LEN;
    chk("rd_base", rd_base, eb);
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("repeat_cnt", 32'(repeat_cnt), 32'(m_rep));
    chk("w_ne_r", 32'(wr_idx != rd_idx), 32'd1);
  endtask

  // One clock: drive inputs, advance model, sample after the edge
  task automatic apply(input bit rst, input bit en, input bit wr, input bit rd);
    reset = rst; enable = en; wr_done = wr; rd_done = rd;
    model_step(rst, en, wr, rd);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic pulse(input bit wr, input bit rd);
    apply(1'b0, 1'b1, wr, rd);
    apply(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int fr0;
    bit wl, rl, rs, en;

    reset = 1'b1; enable = 1'b0; wr_done = 1'b0; rd_done = 1'b0;

    //           rst en wr rd   w  r fr fc dc rc wg rg
    tbl[0]  = '{1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0,   0, 1, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{0, 1, 1, 0,   1, 0, 0, 1, 0, 0, 1, 1};
    tbl[3]  = '{0, 1, 0, 0,   1, 0, 0, 1, 0, 0, 1, 1};
    tbl[4]  = '{0, 1, 1, 0,   2, 0, 1, 2, 0, 0, 1, 1};
    tbl[5]  = '{0, 1, 0, 1,   2, 1, 0, 2, 0, 0, 1, 1};
    tbl[6]  = '{0, 1, 0, 0,   2, 1, 0, 2, 0, 0, 1, 1};
    tbl[7]  = '{0, 1, 0, 1,   2, 1, 0, 2, 0, 1, 1, 1};
    tbl[8]  = '{0, 1, 1, 0,   0, 1, 1, 3, 0, 1, 1, 1};
    tbl[9]  = '{0, 1, 0, 0,   0, 1, 1, 3, 0, 1, 1, 1};
    tbl[10] = '{0, 1, 1, 0,   2, 1, 1, 4, 1, 1, 1, 1};
    tbl[11] = '{0, 1, 0, 0,   2, 1, 1, 4, 1, 1, 1, 1};
    tbl[12] = '{0, 1, 1, 0,   0, 1, 1, 5, 2, 1, 1, 1};
    tbl[13] = '{0, 1, 0, 0,   0, 1, 1, 5, 2, 1, 1, 1};
    tbl[14] = '{0, 1, 1, 1,   2, 0, 0, 6, 3, 1, 1, 1};
    tbl[15] = '{0, 1, 0, 0,   2, 0, 0, 6, 3, 1, 1, 1};
    tbl[16] = '{0, 0, 0, 0,   0, 1, 0, 6, 3, 1, 0, 0};
    tbl[17] = '{0, 1, 0, 0,   0, 1, 0, 6, 3, 1, 1, 0};
    tbl[18] = '{1, 1, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0};

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].wr, tbl[i].rd);
      chk($sformatf("tbl%0d_wr_idx", i), 32'(wr_idx), 32'(tbl[i].w));
      chk($sformatf("tbl%0d_rd_idx", i), 32'(rd_idx), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_fresh", i), 32'(fresh), 32'(tbl[i].fr));
      chk($sformatf("tbl%0d_frame", i), 32'(frame_cnt), 32'(tbl[i].fc));
      chk($sformatf("tbl%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].dc));
      chk($sformatf("tbl%0d_repeat", i), 32'(repeat_cnt), 32'(tbl[i].rc));
      chk($sformatf("tbl%0d_wr_go", i), 32'(wr_go), 32'(tbl[i].wg));
      chk($sformatf("tbl%0d_rd_go", i), 32'(rd_go), 32'(tbl[i].rg));
      if (i == 1) chk("first_wr_base", wr_base, 32'h30880000);
      if (i == 5) chk("run_rd_base", rd_base, 32'h308DDC00);
    end

    // Simultaneous edges with a fresh spare (W=2,R=1,S=0)
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    chk("both_pre_w", 32'(wr_idx), 32'd2);
    chk("both_pre_r", 32'(rd_idx), 32'd1);
    chk("both_pre_fresh", 32'(fresh), 32'd1);
    apply(1'b0, 1'b1, 1'b1, 1'b1);
    chk("both_r", 32'(rd_idx), 32'd2);
    chk("both_w", 32'(wr_idx), 32'd0);
    chk("both_fresh", 32'(fresh), 32'd0);
    chk("both_drop", 32'(drop_cnt), 32'd2);
    apply(1'b0, 1'b1, 1'b0, 1'b0);

    // wr_done held high for ten cycles is one frame
    fr0 = m_frame;
    for (int i = 0; i < 10; i++) apply(1'b0, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    chk("held_wr_one_frame", 32'(frame_cnt), 32'(fr0 + 1));

    // Disable mid-run: idle next cycle, counters kept
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis_wr_go", 32'(wr_go), 32'd0);
    chk("dis_frame", 32'(frame_cnt), 32'd6);
    chk("dis_drop", 32'(drop_cnt), 32'd2);

    // Reset mid-run, then saturate the repeat counter
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_rd_base", rd_base, 32'h308DDC00);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) pulse(1'b0, 1'b1);
    chk("rep_sat_rd_idx", 32'(rd_idx), 32'd0);
    chk("rep_sat", 32'(repeat_cnt), 32'd255);

    // Random stimulus against the model
    wl = 0; rl = 0;
    for (int i = 0; i < 4000; i++) begin
      rs = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 2) == 0) wl = ~wl;
      if ($urandom_range(0, 2) == 0) rl = ~rl;
      apply(rs, en, wl, rl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_frame_triple_buffer_ctrl
